// File: rtl/exu_arb_pkg.sv
// Shared definitions for the execute-ALU arbiter: one-hot op encoding,
// the set of supported ops and the result-buffer state type.
package exu_pkg;

  localparam int ALU_OP_W = 11;
  localparam int ALU_ADD  = 0;
  localparam int ALU_LUI  = 10;

  typedef logic [ALU_OP_W-1:0] aluOp_t;

  localparam aluOp_t OP_ADD         = 11'h001;
  localparam aluOp_t OP_LUI         = 11'h400;
  localparam aluOp_t ALU_LEGAL_MASK = OP_ADD | OP_LUI;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } bufState_t;

  // Legal means exactly one supported bit set; zero and multi-hot are illegal.
  function automatic logic isLegalOp(aluOp_t op);
    return (op == OP_ADD) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/exu_arb_if.sv
// Request, result and handshake bundle between the two requesters,
// the arbiter and writeback.
interface exu_arb_if
  import exu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);

  logic                  r0_valid;
  logic                  r0_ready;
  aluOp_t                r0_aluOp;
  logic [DATA_WIDTH-1:0] r0_src1;
  logic [DATA_WIDTH-1:0] r0_src2;
  logic                  r0_regW;
  logic [ADDR_WIDTH-1:0] r0_regAddr;

  logic                  r1_valid;
  logic                  r1_ready;
  aluOp_t                r1_aluOp;
  logic [DATA_WIDTH-1:0] r1_src1;
  logic [DATA_WIDTH-1:0] r1_src2;

  logic                  o_valid;
  logic                  o_ready;
  logic                  o_src;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_regW;
  logic [ADDR_WIDTH-1:0] o_regAddr;
  logic                  o_illegal;

  // The master side is the requesters plus the writeback consumer.
  modport master (
    output r0_valid, r0_aluOp, r0_src1, r0_src2, r0_regW, r0_regAddr,
    output r1_valid, r1_aluOp, r1_src1, r1_src2,
    output o_ready,
    input  r0_ready, r1_ready,
    input  o_valid, o_src, o_data, o_regW, o_regAddr, o_illegal
  );

  modport slave (
    input  r0_valid, r0_aluOp, r0_src1, r0_src2, r0_regW, r0_regAddr,
    input  r1_valid, r1_aluOp, r1_src1, r1_src2,
    input  o_ready,
    output r0_ready, r1_ready,
    output o_valid, o_src, o_data, o_regW, o_regAddr, o_illegal
  );

endinterface

// File: rtl/exu_arb_alu.sv
// Shared execute ALU: add and lui, with the two terms AND-OR combined so
// unsupported op patterns still produce a defined result.
module alu
  import exu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  aluOp_t                aluOp,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
);

  logic [DATA_WIDTH-1:0] addTerm;

  assign addTerm = src1 + src2;

  assign result  = ({DATA_WIDTH{aluOp[ALU_ADD]}} & addTerm)
                 | ({DATA_WIDTH{aluOp[ALU_LUI]}} & src2);

  assign illegal = !isLegalOp(aluOp);

endmodule

// File: rtl/exu_arb.sv
// Round-robin arbiter between issue (port 0) and AGU (port 1) feeding the
// shared ALU, with a single-entry registered result buffer toward writeback.
module exu_arb
  import exu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  exu_arb_if.slave bus
);

  bufState_t             state;
  logic                  prio;
  logic                  srcQ;
  logic [DATA_WIDTH-1:0] dataQ;
  logic                  regWQ;
  logic [ADDR_WIDTH-1:0] regAddrQ;
  logic                  illegalQ;

  logic                  canAccept;
  logic                  bothValid;
  logic                  anyValid;
  logic                  grantSel;
  aluOp_t                selOp;
  logic [DATA_WIDTH-1:0] selSrc1;
  logic [DATA_WIDTH-1:0] selSrc2;
  logic [DATA_WIDTH-1:0] aluResult;
  logic                  aluIllegal;

  // Readiness depends only on our own buffer and the consumer, so a drain
  // and a refill can happen in the same cycle.
  assign canAccept = !rst && ((state == BUF_EMPTY) || bus.o_ready);
  assign bothValid = bus.r0_valid && bus.r1_valid;
  assign anyValid  = bus.r0_valid || bus.r1_valid;
  assign grantSel  = bothValid ? prio : bus.r1_valid;

  assign bus.r0_ready = canAccept && bus.r0_valid && !grantSel;
  assign bus.r1_ready = canAccept && bus.r1_valid &&  grantSel;

  assign selOp   = grantSel ? bus.r1_aluOp : bus.r0_aluOp;
  assign selSrc1 = grantSel ? bus.r1_src1  : bus.r0_src1;
  assign selSrc2 = grantSel ? bus.r1_src2  : bus.r0_src2;

  alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uAlu (
    .aluOp  (selOp),
    .src1   (selSrc1),
    .src2   (selSrc2),
    .result (aluResult),
    .illegal(aluIllegal)
  );

  // Buffer FSM and result registers. prio moves to the loser only on
  // contested grants; uncontested grants leave fairness history alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BUF_EMPTY;
      prio     <= 1'b0;
      srcQ     <= 1'b0;
      dataQ    <= '0;
      regWQ    <= 1'b0;
      regAddrQ <= '0;
      illegalQ <= 1'b0;
    end else if (canAccept) begin
      if (anyValid) begin
        state    <= BUF_FULL;
        srcQ     <= grantSel;
        dataQ    <= aluResult;
        regWQ    <= !grantSel && bus.r0_regW;
        regAddrQ <= grantSel ? '0 : bus.r0_regAddr;
        illegalQ <= aluIllegal;
        if (bothValid) begin
          prio <= !grantSel;
        end
      end else begin
        state <= BUF_EMPTY;
      end
    end
  end

  assign bus.o_valid   = (state == BUF_FULL);
  assign bus.o_src     = srcQ;
  assign bus.o_data    = dataQ;
  assign bus.o_regW    = regWQ;
  assign bus.o_regAddr = regAddrQ;
  assign bus.o_illegal = illegalQ;

endmodule

// File: tb/tb_exu_arb.sv
// Scoreboard bench for exu_arb: a cycle-level reference model predicts
// grants and results; a separate monitor checks every presented result.
module tb_exu_arb;
  import exu_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic          src;
    logic [DW-1:0] data;
    logic          regW;
    logic [AW-1:0] regAddr;
    logic          illegal;
  } expRes_t;

  logic clk;
  logic rst;

  exu_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  exu_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int      vectors = 0;
  int      errors  = 0;
  expRes_t sbq[$];
  bit      mFull   = 1'b0;
  bit      mPrio   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] refResult(aluOp_t op, logic [DW-1:0] a, logic [DW-1:0] b);
    logic [DW-1:0] sum;
    sum = a + b;
    if (op == OP_ADD) return sum;
    if (op == OP_LUI) return b;
    return (op[ALU_ADD] ? sum : '0) | (op[ALU_LUI] ? b : '0);
  endfunction

  // Reference model: decides the grant from the model's own occupancy and
  // fairness pointer, checks readiness and queues the expected result.
  always @(negedge clk) begin
    int      g;
    bit      canAcc;
    expRes_t e;
    if (rst) begin
      checkOutput("r0ReadyInReset", bus.r0_ready, 0);
      checkOutput("r1ReadyInReset", bus.r1_ready, 0);
      mFull = 1'b0;
      mPrio = 1'b0;
      sbq.delete();
    end else begin
      checkOutput("oValid", bus.o_valid, mFull);
      canAcc = !mFull || bus.o_ready;
      g = -1;
      if (canAcc && (bus.r0_valid || bus.r1_valid)) begin
        if (bus.r0_valid && bus.r1_valid) begin
          g = mPrio;
          mPrio = (g == 0);
        end else begin
          g = bus.r1_valid ? 1 : 0;
        end
        if (g == 0) begin
          e.src = 1'b0; e.data = refResult(bus.r0_aluOp, bus.r0_src1, bus.r0_src2);
          e.regW = bus.r0_regW; e.regAddr = bus.r0_regAddr;
          e.illegal = !(bus.r0_aluOp == OP_ADD || bus.r0_aluOp == OP_LUI);
        end else begin
          e.src = 1'b1; e.data = refResult(bus.r1_aluOp, bus.r1_src1, bus.r1_src2);
          e.regW = 1'b0; e.regAddr = '0;
          e.illegal = !(bus.r1_aluOp == OP_ADD || bus.r1_aluOp == OP_LUI);
        end
        sbq.push_back(e);
        mFull = 1'b1;
      end else if (canAcc) begin
        mFull = 1'b0;
      end
      checkOutput("r0Ready", bus.r0_ready, (g == 0));
      checkOutput("r1Ready", bus.r1_ready, (g == 1));
    end
  end

  // Monitor: compares the presented result against the oldest expectation
  // every cycle it is valid (so stalls must hold), pops on handshake.
  always @(negedge clk) begin
    expRes_t e;
    if (!rst && bus.o_valid) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpectedResult", 1, 0);
      end else begin
        e = sbq[0];
        checkOutput("oSrc", bus.o_src, e.src);
        checkOutput("oData", bus.o_data, e.data);
        checkOutput("oRegW", bus.o_regW, e.regW);
        checkOutput("oRegAddr", bus.o_regAddr, e.regAddr);
        checkOutput("oIllegal", bus.o_illegal, e.illegal);
        if (bus.o_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic applyStimulus(
    input logic v0, input aluOp_t op0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
    input logic w0, input logic [AW-1:0] ad0,
    input logic v1, input aluOp_t op1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
    input logic ordy);
    bus.r0_valid = v0; bus.r0_aluOp = op0; bus.r0_src1 = a0; bus.r0_src2 = b0;
    bus.r0_regW = w0; bus.r0_regAddr = ad0;
    bus.r1_valid = v1; bus.r1_aluOp = op1; bus.r1_src1 = a1; bus.r1_src2 = b1;
    bus.o_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, OP_ADD, 0, 0, 0, 0, 0, OP_ADD, 0, 0, 1);
  endtask

  function automatic aluOp_t randOp();
    int k;
    k = $urandom_range(0, 9);
    if (k < 4) return OP_ADD;
    if (k < 7) return OP_LUI;
    if (k == 7) return '0;
    return aluOp_t'($urandom);
  endfunction

  initial begin
    bit acc0;
    bit acc1;
    rst = 1'b1;
    applyStimulus(0, OP_ADD, 0, 0, 0, 0, 0, OP_ADD, 0, 0, 0);
    applyStimulus(0, OP_ADD, 0, 0, 0, 0, 0, OP_ADD, 0, 0, 0);
    rst = 1'b0;
    checkOutput("resetValid", bus.o_valid, 0);
    checkOutput("resetData", bus.o_data, 0);
    checkOutput("resetRegAddr", bus.o_regAddr, 0);
    checkOutput("resetFlags", {bus.o_src, bus.o_regW, bus.o_illegal}, 0);

    $display("[TB] port 0 add 5+7");
    applyStimulus(1, OP_ADD, 5, 7, 1, 3, 0, OP_ADD, 0, 0, 1);
    checkOutput("firstAddData", bus.o_data, 12);
    checkOutput("firstAddRegAddr", bus.o_regAddr, 3);
    idle(1);

    $display("[TB] dual requests, round robin");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, OP_ADD, 32'(i), 100, 1, 5'(i + 1), 1, OP_LUI, 0, 32'(200 + i), 1);
      checkOutput("rrSrc", bus.o_src, (i % 2));
    end

    $display("[TB] stall with both ports valid");
    applyStimulus(1, OP_ADD, 10, 1, 1, 9, 1, OP_ADD, 20, 2, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, OP_ADD, 10, 1, 1, 9, 1, OP_ADD, 20, 2, 0);
    applyStimulus(1, OP_ADD, 10, 1, 1, 9, 1, OP_ADD, 20, 2, 1);
    applyStimulus(1, OP_ADD, 10, 1, 1, 9, 1, OP_ADD, 20, 2, 1);
    idle(2);

    $display("[TB] port 1 lui");
    applyStimulus(0, OP_ADD, 0, 0, 0, 0, 1, OP_LUI, 32'hDEAD, 32'h12345000, 1);
    checkOutput("luiData", bus.o_data, 32'h12345000);
    checkOutput("luiDest", {bus.o_src, bus.o_regW, bus.o_regAddr}, {1'b1, 1'b0, 5'd0});

    $display("[TB] wrap-around and illegal op");
    applyStimulus(1, OP_ADD, 32'hFFFFFFFF, 1, 1, 7, 0, OP_ADD, 0, 0, 1);
    checkOutput("wrapData", bus.o_data, 0);
    applyStimulus(1, '0, 32'h55, 32'h66, 1, 7, 0, OP_ADD, 0, 0, 1);
    checkOutput("zeroOpIllegal", bus.o_illegal, 1);
    checkOutput("zeroOpData", bus.o_data, 0);
    idle(1);

    $display("[TB] reset while full and stalled");
    applyStimulus(1, OP_ADD, 1, 2, 1, 4, 1, OP_ADD, 3, 4, 1);
    applyStimulus(1, OP_ADD, 1, 2, 1, 4, 1, OP_ADD, 3, 4, 0);
    rst = 1'b1;
    applyStimulus(1, OP_ADD, 1, 2, 1, 4, 1, OP_ADD, 3, 4, 0);
    rst = 1'b0;
    checkOutput("midResetValid", bus.o_valid, 0);
    applyStimulus(1, OP_ADD, 8, 8, 1, 2, 1, OP_LUI, 0, 32'hABC, 1);
    checkOutput("postResetFirstGrant", bus.o_src, 0);
    idle(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      acc0 = bus.r0_valid && bus.r0_ready;
      acc1 = bus.r1_valid && bus.r1_ready;
      @(posedge clk);
      #1;
      if (!bus.r0_valid || acc0) begin
        bus.r0_valid = ($urandom_range(0, 3) != 0);
        bus.r0_aluOp = randOp();
        bus.r0_src1 = $urandom; bus.r0_src2 = $urandom;
        bus.r0_regW = $urandom_range(0, 1);
        bus.r0_regAddr = AW'($urandom);
      end
      if (!bus.r1_valid || acc1) begin
        bus.r1_valid = ($urandom_range(0, 3) != 0);
        bus.r1_aluOp = randOp();
        bus.r1_src1 = $urandom; bus.r1_src2 = $urandom;
      end
      bus.o_ready = ($urandom_range(0, 3) != 0);
    end

    idle(4);
    checkOutput("scoreboardDrained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/exu_arb.md
# exu_arb

Two-requester arbiter and result buffer for the shared execute ALU. Sits between the decode/issue path (port 0) and the load/store address-generation path (port 1) on the input side, and writeback on the output side. Grants one valid/ready request per cycle using round-robin priority, drives the `alu` sub-module with the granted operands, and registers the result in a single-entry output buffer with a valid/ready handshake.

## Interface
- `ADDR_WIDTH`, default 5: register-file address width.
- `DATA_WIDTH`, default 32: operand and result width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `r0_valid`  in  1  port 0 request valid.
- `r0_ready`  out  1  port 0 request accepted this cycle.
- `r0_aluOp`  in  11  port 0 one-hot ALU op; bit 0 is add, bit 10 is lui.
- `r0_src1`, `r0_src2`  in  DATA_WIDTH  port 0 operands.
- `r0_regW`  in  1  port 0 register-write enable.
- `r0_regAddr`  in  ADDR_WIDTH  port 0 destination register.
- `r1_valid`, `r1_ready`, `r1_aluOp`, `r1_src1`, `r1_src2`  same widths and meanings as port 0. Port 1 has no register destination.
- `o_valid`  out  1  result buffer holds a result.
- `o_ready`  in  1  consumer accepts the result.
- `o_src`  out  1  requester that produced the result (0 or 1).
- `o_data`  out  DATA_WIDTH  ALU result.
- `o_regW`  out  1  write enable; forced to 0 for port 1 results.
- `o_regAddr`  out  ADDR_WIDTH  destination register; 0 for port 1 results.
- `o_illegal`  out  1  `aluOp` was not one of {add, lui}.

## Operation
- Buffer states:
  - EMPTY: `o_valid` = 0.
  - FULL: `o_valid` = 1.
- `can_accept` = EMPTY or (FULL and `o_ready`). The buffer drains and refills in the same cycle, so throughput is one result per cycle.
- Grant rule, when `can_accept`:
  - Only one port valid: that port is granted.
  - Both ports valid: the port selected by the `prio` pointer is granted.
  - `rN_ready` = `can_accept` and (grant == N).
  - `rN_ready` never depends combinationally on `o_valid` of the other port.
- On a grant: the ALU computes from the granted operands, and `o_data`, `o_src`, `o_regW`, `o_regAddr` and `o_illegal` are loaded. The buffer becomes or stays FULL.
- `prio` is updated on a grant only when both ports were valid; it then points to the port that lost. Single-port grants leave `prio` unchanged.
- FULL, `o_ready` = 1, no request valid: the buffer goes to EMPTY.
- FULL, `o_ready` = 0: all outputs hold stable, both `rN_ready` = 0, `prio` holds.
- ALU function, mod 2^DATA_WIDTH:
  - add: `src1 + src2`.
  - lui: `src2`.
  - Any other `aluOp` value (zero, multi-hot, or an unsupported bit): `o_data` = bitwise AND-OR of the add and lui terms per the ALU definition, and `o_illegal` = 1.
- Requesters hold their payload stable while `valid` = 1 and `ready` = 0. The block does not check this.

## Timing
- Latency is 1 cycle: a request granted in cycle N has `o_valid` = 1 in cycle N+1.
- Reset, in the cycle after `rst` = 1:
  - `o_valid`, `o_src`, `o_regW`, `o_illegal` = 0.
  - `o_data` and `o_regAddr` = 0.
  - `prio` = 0 (port 0 favoured).
  - Both `rN_ready` = 0 while `rst` is asserted.
- Reset mid-operation discards a buffered result; no handshake completes in the reset cycle.
- Simultaneous drain and grant in the same cycle: the new result replaces the old one. No bubble, no loss.

## Structure
- Shared package `exu_pkg`: the ALU op bit indices (`ALU_ADD` = 0, `ALU_LUI` = 10), the op width of 11, and the legal-op mask.
- Sub-module: the existing `alu`, instantiated once and fed by the grant mux.
- The grant logic lives inline. It is small enough that it needs no separate arbiter module.

## Test plan
- Reset, then port 0 only: `add` with 5 and 7, `regAddr` 3. Expect `o_valid` 1 cycle later with `o_data` = 12, `o_src` = 0, `o_regW` = 1, `o_regAddr` = 3.
- Both ports valid for 4 consecutive cycles with `o_ready` = 1. Expect grants in the order 0, 1, 0, 1 and one result every cycle.
- `o_ready` = 0 for 3 cycles while both ports are valid. Expect outputs stable, both `rN_ready` = 0 and `prio` unchanged; after release, grants resume with no lost or duplicated result.
- Port 1 `lui` with `src2` = 0x12345000. Expect `o_data` = 0x12345000, `o_regW` = 0, `o_regAddr` = 0, `o_src` = 1.
- Port 0 `add` of 0xFFFFFFFF and 1. Expect `o_data` = 0 (wrap-around). Then `aluOp` = 0. Expect `o_illegal` = 1 and `o_data` = 0.
- Assert `rst` while the buffer is FULL and `o_ready` = 0. Expect `o_valid` = 0 next cycle and `prio` = 0; a subsequent dual request grants port 0 first.
